// File: rtl/bram_arb_pkg.sv
// rtl/bram_arb_pkg.sv - shared types and helpers for the BRAM arbiter
package bram_arb_pkg;

   typedef enum logic {ARB, LOCKED} arb_state_t;

   localparam int MAX_REQ = 8;

   // The counter only has to count up to max_lock.
   function automatic int lock_cnt_width(input int max_lock);
      return $clog2(max_lock + 1);
   endfunction

endpackage

// File: rtl/bram_arbiter_rr_picker.sv
// rtl/bram_arbiter_rr_picker.sv - round-robin one-hot picker starting at ptr
module rr_picker
   import bram_arb_pkg::*;
#(
   parameter int N  = 2,
   parameter int PW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic [N-1:0]  gnt
);

   logic found;

   // Rotate by ptr, take the first set bit, map it back to its requester slot.
   always_comb begin
      gnt   = '0;
      found = 1'b0;
      for (int k = 0; k < N; k++) begin
         logic [PW-1:0] idx;
         idx = PW'((int'(ptr) + k) % N);
         if (!found && req[idx]) begin
            gnt[idx] = 1'b1;
            found    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/bram_arbiter.sv
// rtl/bram_arbiter.sv - round-robin single-port BRAM arbiter with bounded lock
module bram_arbiter
   import bram_arb_pkg::*;
#(
   parameter int N_REQ        = 2,
   parameter int MEMORY_DEPTH = 4092,
   parameter int DATA_WIDTH   = 16,
   parameter int MAX_LOCK     = 16,
   localparam int ADDRESS_WIDTH = $clog2(MEMORY_DEPTH)
) (
   input  logic                           clk,
   input  logic                           rstN,
   input  logic [N_REQ-1:0]               req,
   input  logic [N_REQ-1:0]               wr_in,
   input  logic [N_REQ-1:0]               lock,
   input  logic [N_REQ*ADDRESS_WIDTH-1:0] addr_in,
   input  logic [N_REQ*DATA_WIDTH-1:0]    wdata_in,
   output logic [N_REQ-1:0]               gnt,
   output logic [N_REQ-1:0]               rvalid,
   output logic [DATA_WIDTH-1:0]          rdata,
   output logic                           bram_wr,
   output logic [ADDRESS_WIDTH-1:0]       bram_address,
   output logic [DATA_WIDTH-1:0]          bram_data,
   input  logic [DATA_WIDTH-1:0]          bram_q
);

   localparam int AW = ADDRESS_WIDTH;
   localparam int PW = $clog2(N_REQ);
   localparam int CW = lock_cnt_width(MAX_LOCK);

   arb_state_t     state, state_n;
   logic [PW-1:0]  rr_ptr, rr_ptr_n;
   logic [PW-1:0]  owner, owner_n;
   logic [CW-1:0]  lock_cnt, lock_cnt_n;
   logic [N_REQ-1:0] rvalid_r;

   logic [N_REQ-1:0] pick_req;
   logic [PW-1:0]    pick_ptr;
   logic [N_REQ-1:0] pick_gnt;
   logic [PW-1:0]    gidx;
   logic             any_gnt;

   function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] i);
      return PW'((int'(i) + 1) % N_REQ);
   endfunction

   // While locked, only the owner is visible to the picker.
   always_comb begin
      pick_req = req;
      pick_ptr = rr_ptr;
      if (state == LOCKED) begin
         pick_req = req & ({{(N_REQ-1){1'b0}}, 1'b1} << owner);
         pick_ptr = owner;
      end
   end

   rr_picker #(.N(N_REQ), .PW(PW)) u_picker (
      .req (pick_req),
      .ptr (pick_ptr),
      .gnt (pick_gnt)
   );

   // Grant is suppressed during reset; encode the winner index for the mux.
   always_comb begin
      gnt     = rstN ? pick_gnt : '0;
      any_gnt = |gnt;
      gidx    = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (gnt[i]) gidx = PW'(i);
      end
   end

   // Route the winner's access to the BRAM; idle bus when nobody is granted.
   always_comb begin
      bram_wr      = 1'b0;
      bram_address = '0;
      bram_data    = '0;
      if (any_gnt) begin
         bram_wr      = wr_in[gidx];
         bram_address = addr_in[int'(gidx)*AW +: AW];
         bram_data    = wdata_in[int'(gidx)*DATA_WIDTH +: DATA_WIDTH];
      end
   end

   // Arbitration FSM: pointer advance, lock entry, lock release and timeout.
   always_comb begin
      state_n    = state;
      rr_ptr_n   = rr_ptr;
      owner_n    = owner;
      lock_cnt_n = lock_cnt;
      case (state)
         ARB: begin
            if (any_gnt) begin
               rr_ptr_n = next_ptr(gidx);
               if (lock[gidx]) begin
                  state_n    = LOCKED;
                  owner_n    = gidx;
                  lock_cnt_n = CW'(1);
               end
            end
         end
         LOCKED: begin
            // The grant that brings the hold to MAX_LOCK cycles is the last one.
            if (!req[owner] || !lock[owner] || lock_cnt == CW'(MAX_LOCK - 1)) begin
               state_n    = ARB;
               rr_ptr_n   = next_ptr(owner);
               lock_cnt_n = '0;
            end else begin
               lock_cnt_n = lock_cnt + CW'(1);
            end
         end
         default: state_n = ARB;
      endcase
   end

   // State registers and the one-cycle read-return strobe.
   always_ff @(posedge clk) begin
      if (!rstN) begin
         state    <= ARB;
         rr_ptr   <= '0;
         owner    <= '0;
         lock_cnt <= '0;
         rvalid_r <= '0;
      end else begin
         state    <= state_n;
         rr_ptr   <= rr_ptr_n;
         owner    <= owner_n;
         lock_cnt <= lock_cnt_n;
         rvalid_r <= gnt & ~wr_in;
      end
   end

   // A read in flight when reset asserts is never reported.
   assign rvalid = rvalid_r & {N_REQ{rstN}};
   assign rdata  = bram_q;

endmodule

// File: tb/tb_bram_arbiter.sv
// tb/tb_bram_arbiter.sv - directed vector bench for bram_arbiter
module tb_bram_arbiter;

   logic        clk = 1'b0;
   logic        rstN;
   logic [1:0]  req, wr_in, lock;
   logic [11:0] a0, a1;
   logic [15:0] wd0;
   logic [1:0]  gnt, rvalid;
   logic [15:0] rdata;
   logic        bram_wr;
   logic [11:0] bram_address;
   logic [15:0] bram_data;
   logic [15:0] bram_q;
   logic [15:0] mem [0:7];

   int passed = 0;
   int total  = 0;

   typedef struct {
      logic        rstn;
      logic [1:0]  req, wr, lk;
      logic [11:0] a0, a1;
      logic [15:0] wd0;
      logic [1:0]  g, rv;
      logic        bwr;
      logic [11:0] ba;
      logic [15:0] bd;
      logic        cq;
      logic [15:0] q;
   } vec_t;

   vec_t vecs[$];

   bram_arbiter #(.N_REQ(2), .MEMORY_DEPTH(4092), .DATA_WIDTH(16), .MAX_LOCK(4)) dut (
      .clk          (clk),
      .rstN         (rstN),
      .req          (req),
      .wr_in        (wr_in),
      .lock         (lock),
      .addr_in      ({a1, a0}),
      .wdata_in     ({16'h0000, wd0}),
      .gnt          (gnt),
      .rvalid       (rvalid),
      .rdata        (rdata),
      .bram_wr      (bram_wr),
      .bram_address (bram_address),
      .bram_data    (bram_data),
      .bram_q       (bram_q)
   );

   always #5 clk = ~clk;

   // Small BRAM model: only the low address bits are used by the vectors.
   always @(posedge clk) begin
      if (!rstN) begin
         for (int i = 0; i < 8; i++) mem[i] <= 16'(i) ^ 16'hA5A5;
      end else if (bram_wr) begin
         mem[bram_address[2:0]] <= bram_data;
      end
      bram_q <= mem[bram_address[2:0]];
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   function automatic vec_t mk(input logic rstn, input logic [1:0] rq, input logic [1:0] w,
                               input logic [1:0] lk, input logic [11:0] x0, input logic [11:0] x1,
                               input logic [15:0] d0, input logic [1:0] g, input logic [1:0] rv,
                               input logic bwr, input logic [11:0] ba, input logic [15:0] bd,
                               input logic cq, input logic [15:0] q);
      vec_t v;
      v.rstn = rstn; v.req = rq; v.wr = w; v.lk = lk; v.a0 = x0; v.a1 = x1; v.wd0 = d0;
      v.g = g; v.rv = rv; v.bwr = bwr; v.ba = ba; v.bd = bd; v.cq = cq; v.q = q;
      return v;
   endfunction

   initial begin
      rstN = 1'b0; req = 2'b00; wr_in = 2'b00; lock = 2'b00;
      a0 = 12'd3; a1 = 12'd7; wd0 = 16'h0000;

      // reset held with both requesting
      for (int i = 0; i < 3; i++)
         vecs.push_back(mk(0, 2'b11, 2'b00, 2'b00, 3, 7, 0,      2'b00, 2'b00, 0, 0, 0, 0, 0));
      // release and round-robin reads
      vecs.push_back(mk(1, 2'b11, 2'b00, 2'b00, 3, 7, 0,         2'b01, 2'b00, 0, 3, 0, 0, 0));
      vecs.push_back(mk(1, 2'b11, 2'b00, 2'b00, 3, 7, 0,         2'b10, 2'b01, 0, 7, 0, 1, 16'hA5A6));
      vecs.push_back(mk(1, 2'b11, 2'b00, 2'b00, 3, 7, 0,         2'b01, 2'b10, 0, 3, 0, 1, 16'hA5A2));
      vecs.push_back(mk(1, 2'b11, 2'b00, 2'b00, 3, 7, 0,         2'b10, 2'b01, 0, 7, 0, 1, 16'hA5A6));
      vecs.push_back(mk(1, 2'b11, 2'b00, 2'b00, 3, 7, 0,         2'b01, 2'b10, 0, 3, 0, 1, 16'hA5A2));
      vecs.push_back(mk(1, 2'b11, 2'b00, 2'b00, 3, 7, 0,         2'b10, 2'b01, 0, 7, 0, 1, 16'hA5A6));
      vecs.push_back(mk(1, 2'b00, 2'b00, 2'b00, 3, 7, 0,         2'b00, 2'b10, 0, 0, 0, 1, 16'hA5A2));
      // write 0x12 to 5 by req0, then read 5 by req1
      vecs.push_back(mk(1, 2'b01, 2'b01, 2'b00, 5, 7, 16'h0012, 2'b01, 2'b00, 1, 5, 16'h0012, 0, 0));
      vecs.push_back(mk(1, 2'b10, 2'b00, 2'b00, 5, 5, 0,         2'b10, 2'b00, 0, 5, 0, 0, 0));
      vecs.push_back(mk(1, 2'b00, 2'b00, 2'b00, 3, 7, 0,         2'b00, 2'b10, 0, 0, 0, 1, 16'h0012));
      // locked 4-read burst by req0, req1 waiting
      vecs.push_back(mk(1, 2'b11, 2'b00, 2'b01, 3, 7, 0,         2'b01, 2'b00, 0, 3, 0, 0, 0));
      vecs.push_back(mk(1, 2'b11, 2'b00, 2'b01, 3, 7, 0,         2'b01, 2'b01, 0, 3, 0, 1, 16'hA5A6));
      vecs.push_back(mk(1, 2'b11, 2'b00, 2'b01, 3, 7, 0,         2'b01, 2'b01, 0, 3, 0, 1, 16'hA5A6));
      vecs.push_back(mk(1, 2'b11, 2'b00, 2'b00, 3, 7, 0,         2'b01, 2'b01, 0, 3, 0, 1, 16'hA5A6));
      vecs.push_back(mk(1, 2'b11, 2'b00, 2'b00, 3, 7, 0,         2'b10, 2'b01, 0, 7, 0, 1, 16'hA5A6));
      vecs.push_back(mk(1, 2'b00, 2'b00, 2'b00, 3, 7, 0,         2'b00, 2'b10, 0, 0, 0, 1, 16'hA5A2));
      // lock held forever by req0: timeout after 4 grants
      vecs.push_back(mk(1, 2'b11, 2'b00, 2'b01, 3, 7, 0,         2'b01, 2'b00, 0, 3, 0, 0, 0));
      vecs.push_back(mk(1, 2'b11, 2'b00, 2'b01, 3, 7, 0,         2'b01, 2'b01, 0, 3, 0, 1, 16'hA5A6));
      vecs.push_back(mk(1, 2'b11, 2'b00, 2'b01, 3, 7, 0,         2'b01, 2'b01, 0, 3, 0, 1, 16'hA5A6));
      vecs.push_back(mk(1, 2'b11, 2'b00, 2'b01, 3, 7, 0,         2'b01, 2'b01, 0, 3, 0, 1, 16'hA5A6));
      vecs.push_back(mk(1, 2'b11, 2'b00, 2'b01, 3, 7, 0,         2'b10, 2'b01, 0, 7, 0, 1, 16'hA5A6));
      vecs.push_back(mk(1, 2'b11, 2'b00, 2'b01, 3, 7, 0,         2'b01, 2'b10, 0, 3, 0, 1, 16'hA5A2));
      // owner drops req: lock released without a grant
      vecs.push_back(mk(1, 2'b00, 2'b00, 2'b00, 3, 7, 0,         2'b00, 2'b01, 0, 0, 0, 1, 16'hA5A6));

      @(posedge clk); @(posedge clk); #1;

      foreach (vecs[n]) begin
         rstN = vecs[n].rstn; req = vecs[n].req; wr_in = vecs[n].wr; lock = vecs[n].lk;
         a0 = vecs[n].a0; a1 = vecs[n].a1; wd0 = vecs[n].wd0;
         @(negedge clk);
         check($sformatf("v%0d gnt", n),          32'(gnt),          32'(vecs[n].g));
         check($sformatf("v%0d rvalid", n),       32'(rvalid),       32'(vecs[n].rv));
         check($sformatf("v%0d bram_wr", n),      32'(bram_wr),      32'(vecs[n].bwr));
         check($sformatf("v%0d bram_address", n), 32'(bram_address), 32'(vecs[n].ba));
         check($sformatf("v%0d bram_data", n),    32'(bram_data),    32'(vecs[n].bd));
         if (vecs[n].cq)
            check($sformatf("v%0d rdata", n),     32'(rdata),        32'(vecs[n].q));
         @(posedge clk); #1;
      end

      // reset the cycle after a read grant: its rvalid never appears
      rstN = 1'b1; req = 2'b01; wr_in = 2'b00; lock = 2'b00; a0 = 12'd3;
      @(negedge clk);
      check("midrst grant", 32'(gnt), 32'h1);
      @(posedge clk); #1;
      rstN = 1'b0; req = 2'b00;
      @(negedge clk);
      check("midrst rvalid in reset", 32'(rvalid), 32'h0);
      check("midrst gnt in reset",    32'(gnt),    32'h0);
      @(posedge clk); #1;
      rstN = 1'b1;
      @(negedge clk);
      check("midrst rvalid after", 32'(rvalid), 32'h0);
      @(posedge clk); #1;
      req = 2'b11;
      @(negedge clk);
      check("midrst ptr reset", 32'(gnt), 32'h1);
      @(posedge clk); #1;
      req = 2'b00;
      @(negedge clk);
      check("midrst rvalid resumes", 32'(rvalid), 32'h1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
